// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receive and transmit paths.
//   - state encodings for the receiver FSM
//   - default bit divisor (10 MHz clock, 115200 baud)
//   - data width and a parity helper
package uart_pkg;

    localparam int UART_CLKS_PER_BIT = 87;
    localparam int UART_DATA_W       = 8;

    typedef logic [UART_DATA_W-1:0] uart_byte_t;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // Parity bit a transmitter appends for byte d (odd = 0 -> even parity).
    function automatic logic parity_of(input uart_byte_t d, input logic odd);
        return (^d) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: byte delivery and status bundle between the UART receiver
// (master) and its consumer (slave).
//   uart_rx_ack         consumer -> rx : byte in uart_rx_data has been taken
//   uart_rx_data        rx -> consumer : received byte
//   uart_rx_valid       rx -> consumer : uart_rx_data holds an unread byte
//   uart_rx_busy        rx -> consumer : frame reception in progress
//   uart_rx_frame_err   rx -> consumer : one-cycle pulse, stop bit was 0
//   uart_rx_overrun     rx -> consumer : one-cycle pulse, unread byte overwritten
//   uart_rx_parity_err  rx -> consumer : one-cycle pulse, parity mismatch
interface uart_rx_if;
    import uart_pkg::*;

    logic       uart_rx_ack;
    uart_byte_t uart_rx_data;
    logic       uart_rx_valid;
    logic       uart_rx_busy;
    logic       uart_rx_frame_err;
    logic       uart_rx_overrun;
    logic       uart_rx_parity_err;

    modport master (
        input  uart_rx_ack,
        output uart_rx_data, uart_rx_valid, uart_rx_busy,
        output uart_rx_frame_err, uart_rx_overrun, uart_rx_parity_err
    );

    modport slave (
        output uart_rx_ack,
        input  uart_rx_data, uart_rx_valid, uart_rx_busy,
        input  uart_rx_frame_err, uart_rx_overrun, uart_rx_parity_err
    );

endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchronizer for asynchronous inputs, reset to
// RST_VAL so an idle-high line does not look like activity after reset.
//   clk        system clock
//   rst_n_clk  asynchronous, active-low reset
//   d          asynchronous input
//   q          synchronized output
module uart_rx_sync #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '1
) (
    input  logic             clk,
    input  logic             rst_n_clk,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n_clk) begin
        if (!rst_n_clk) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver, 8N1 by default, delivering bytes through a
// valid/ack holding register and flagging framing errors and overruns.
// Optional macro UART_RX_PARITY_EN adds a parity bit (8E1 / 8O1 by PARITY_ODD).
//   clk        system clock
//   rst_n_clk  asynchronous, active-low reset
//   uart_rxd   serial line, idle high, asynchronous to clk
//   rx         uart_rx_if master: data/valid/ack, busy and error pulses
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | waiting for a falling edge on the synchronized line
// ST_START  | waiting half a bit, then confirming the start bit is low
// ST_DATA   | sampling 8 data bits mid-bit, LSB first
// ST_PARITY | sampling the parity bit (UART_RX_PARITY_EN builds only)
// ST_STOP   | sampling the stop bit; deliver or flag, back to ST_IDLE
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic     clk,
    input  logic     rst_n_clk,
    input  logic     uart_rxd,
    uart_rx_if.master rx
);

    localparam int            CW      = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] ONE     = CW'(1);

    logic          rxd_s;
    logic          rxd_q;
    logic          fall;
    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic          tick;
    logic [2:0]    bit_idx;
    uart_byte_t    shift;
    logic          stop_take;
    logic          par_bad;
    logic          good;
    uart_byte_t    data_r;
    logic          valid_r;
    logic          frame_err_r;
    logic          overrun_r;

    uart_rx_sync #(.WIDTH(1), .RST_VAL(1'b1)) u_sync (
        .clk       (clk),
        .rst_n_clk (rst_n_clk),
        .d         (uart_rxd),
        .q         (rxd_s)
    );

    assign fall      = rxd_q & ~rxd_s;
    assign tick      = (cnt == '0);
    assign stop_take = (state == ST_STOP) && tick;

`ifdef UART_RX_PARITY_EN
    logic par_bit;
    logic parity_err_r;

    assign par_bad = (par_bit != parity_of(shift, PARITY_ODD));

    always_ff @(posedge clk or negedge rst_n_clk) begin
        if (!rst_n_clk) begin
            par_bit      <= 1'b0;
            parity_err_r <= 1'b0;
        end else begin
            if (state == ST_PARITY && tick)
                par_bit <= rxd_s;
            parity_err_r <= stop_take & par_bad;
        end
    end

    assign rx.uart_rx_parity_err = parity_err_r;
`else
    assign par_bad = 1'b0;
    // PARITY_ODD has no effect in 8N1 builds; the AND keeps the output at 0.
    assign rx.uart_rx_parity_err = PARITY_ODD & 1'b0;
`endif

    assign good = stop_take & rxd_s & ~par_bad;

    always_ff @(posedge clk or negedge rst_n_clk) begin
        if (!rst_n_clk) begin
            rxd_q   <= 1'b1;
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            rxd_q <= rxd_s;
            case (state)
                ST_IDLE: begin
                    if (fall) begin
                        cnt   <= HALF_M1;
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (!rxd_s) begin
                            cnt     <= FULL_M1;
                            bit_idx <= '0;
                            state   <= ST_DATA;
                        end else begin
                            state   <= ST_IDLE;
                        end
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        shift   <= {rxd_s, shift[UART_DATA_W-1:1]};
                        cnt     <= FULL_M1;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        cnt   <= FULL_M1;
                        state <= ST_STOP;
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end
                ST_STOP: begin
                    // Leave mid stop bit so a back-to-back start edge is seen.
                    if (tick)
                        state <= ST_IDLE;
                    else
                        cnt <= cnt - ONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Holding register: a new byte always wins over ack; overrun only when
    // the old byte was still unread and not being acked this cycle.
    always_ff @(posedge clk or negedge rst_n_clk) begin
        if (!rst_n_clk) begin
            data_r      <= '0;
            valid_r     <= 1'b0;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            frame_err_r <= stop_take & ~rxd_s;
            overrun_r   <= good & valid_r & ~rx.uart_rx_ack;
            if (good) begin
                data_r  <= shift;
                valid_r <= 1'b1;
            end else if (rx.uart_rx_ack) begin
                valid_r <= 1'b0;
            end
        end
    end

    assign rx.uart_rx_data      = data_r;
    assign rx.uart_rx_valid     = valid_r;
    assign rx.uart_rx_busy      = (state != ST_IDLE);
    assign rx.uart_rx_frame_err = frame_err_r;
    assign rx.uart_rx_overrun   = overrun_r;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx at CLKS_PER_BIT = 16.
// Frames are built bit by bit from the byte value; a queue of expected
// bytes and counts of expected error pulses form the reference.
module tb_uart_rx;

    localparam int C    = 16;
    localparam int HALF = C / 2;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 10;
`else
    localparam int NBITS = 9;
`endif
    localparam int LAT = 3 + HALF + NBITS * C;

    logic clk = 1'b0;
    logic rst_n_clk = 1'b0;
    logic rxd = 1'b1;
    logic auto_ack = 1'b0;
    logic auto_ack_r = 1'b0;
    logic man_ack = 1'b0;
    logic valid_q = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int pe_cnt = 0;
    int vr_cnt = 0;
    int extra_cnt = 0;
    logic [7:0] exp_q[$];

    always #50 clk = ~clk;

    uart_rx_if rif ();
    assign rif.uart_rx_ack = auto_ack ? auto_ack_r : man_ack;

    uart_rx #(.CLKS_PER_BIT(C), .PARITY_ODD(1'b0)) dut (
        .clk       (clk),
        .rst_n_clk (rst_n_clk),
        .uart_rxd  (rxd),
        .rx        (rif.master)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pulse counters and auto-ack consumer checking against the expected queue.
    always @(negedge clk) begin
        if (rif.uart_rx_frame_err)  fe_cnt++;
        if (rif.uart_rx_overrun)    ov_cnt++;
        if (rif.uart_rx_parity_err) pe_cnt++;
        if (rif.uart_rx_valid && !valid_q) vr_cnt++;
        valid_q = rif.uart_rx_valid;
        if (auto_ack && rif.uart_rx_valid && !auto_ack_r) begin
            if (exp_q.size() == 0) extra_cnt++;
            else chk("rx_data", rif.uart_rx_data, exp_q.pop_front());
            auto_ack_r = 1'b1;
        end else begin
            auto_ack_r = 1'b0;
        end
    end

    task automatic send_frame(input logic [7:0] b, input logic par_flip,
                              input logic stop, input int idle);
        rxd = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (C) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rxd = (^b) ^ par_flip;
        repeat (C) @(negedge clk);
`else
        if (par_flip) rxd = ~rxd;
`endif
        rxd = stop;
        repeat (C) @(negedge clk);
        rxd = 1'b1;
        repeat (idle) @(negedge clk);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc;
        int fe0, ov0, pe0, vr0, nbad, npbad;
        logic [7:0] msg [11] = '{8'h42, 8'h61, 8'h70, 8'h74, 8'h69, 8'h73,
                                 8'h74, 8'h65, 8'h20, 8'h21, 8'h0A};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_data", rif.uart_rx_data, 8'h00);
        chk("rst_valid", rif.uart_rx_valid, 1'b0);
        chk("rst_busy", rif.uart_rx_busy, 1'b0);
        chk("rst_errs", {rif.uart_rx_frame_err, rif.uart_rx_overrun, rif.uart_rx_parity_err}, 3'b000);
        rst_n_clk = 1'b1;
        repeat (5) @(negedge clk);

        // Single frame, manual ack 2 cycles after valid
        fork
            send_frame(8'h42, 1'b0, 1'b1, 4);
            begin
                cyc = 0;
                do begin
                    @(negedge clk);
                    cyc++;
                end while (!rif.uart_rx_valid && cyc < 400);
                chk("single_lat_ok", (cyc >= LAT - 1 && cyc <= LAT + 1), 1'b1);
                chk("single_data", rif.uart_rx_data, 8'h42);
                repeat (2) @(negedge clk);
                chk("single_hold", rif.uart_rx_valid, 1'b1);
                man_ack = 1'b1;
                @(negedge clk);
                man_ack = 1'b0;
                chk("single_clear", rif.uart_rx_valid, 1'b0);
            end
        join
        chk("single_errs", fe_cnt + ov_cnt + pe_cnt, 0);

        // Back-to-back message with auto ack
        auto_ack = 1'b1;
        vr0 = vr_cnt;
        foreach (msg[i]) exp_q.push_back(msg[i]);
        foreach (msg[i]) send_frame(msg[i], 1'b0, 1'b1, 0);
        repeat (6) @(negedge clk);
        chk("b2b_count", vr_cnt - vr0, 11);
        chk("b2b_left", exp_q.size(), 0);
        chk("b2b_overrun", ov_cnt, 0);

        // Framing error then a good byte
        fe0 = fe_cnt; vr0 = vr_cnt;
        send_frame(8'hA5, 1'b0, 1'b0, 20);
        chk("ferr_pulse", fe_cnt - fe0, 1);
        chk("ferr_novalid", vr_cnt - vr0, 0);
        exp_q.push_back(8'h21);
        send_frame(8'h21, 1'b0, 1'b1, 6);
        chk("ferr_recover_left", exp_q.size(), 0);
        auto_ack = 1'b0;

        // Glitch rejection
        vr0 = vr_cnt;
        rxd = 1'b0;
        repeat (3) @(negedge clk);
        rxd = 1'b1;
        repeat (2) @(negedge clk);
        chk("glitch_busy", rif.uart_rx_busy, 1'b1);
        repeat (9) @(negedge clk);
        chk("glitch_idle", rif.uart_rx_busy, 1'b0);
        chk("glitch_novalid", vr_cnt - vr0, 0);

        // Reset in the middle of 0x74
        fe0 = fe_cnt;
        fork
            send_frame(8'h74, 1'b0, 1'b1, 0);
            begin
                repeat (60) @(negedge clk);
                chk("prerst_busy", rif.uart_rx_busy, 1'b1);
                rst_n_clk = 1'b0;
                #1;
                chk("midrst_busy", rif.uart_rx_busy, 1'b0);
                chk("midrst_valid", rif.uart_rx_valid, 1'b0);
                chk("midrst_data", rif.uart_rx_data, 8'h00);
            end
        join
        repeat (4) @(negedge clk);
        rst_n_clk = 1'b1;
        repeat (10) @(negedge clk);
        auto_ack = 1'b1;
        exp_q.push_back(8'h61);
        send_frame(8'h61, 1'b0, 1'b1, 6);
        chk("postrst_left", exp_q.size(), 0);
        chk("postrst_ferr", fe_cnt - fe0, 0);
        auto_ack = 1'b0;

        // Overrun: two bytes, no ack
        ov0 = ov_cnt;
        send_frame(8'h61, 1'b0, 1'b1, 0);
        send_frame(8'h70, 1'b0, 1'b1, 4);
        chk("ovr_pulse", ov_cnt - ov0, 1);
        chk("ovr_data", rif.uart_rx_data, 8'h70);
        chk("ovr_valid", rif.uart_rx_valid, 1'b1);
        man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
        chk("ovr_clear", rif.uart_rx_valid, 1'b0);

`ifdef UART_RX_PARITY_EN
        // Parity: wrong then right parity bit on 0x74 (four ones, even parity 0)
        auto_ack = 1'b1;
        pe0 = pe_cnt; vr0 = vr_cnt;
        send_frame(8'h74, 1'b1, 1'b1, 6);
        chk("par_pulse", pe_cnt - pe0, 1);
        chk("par_novalid", vr_cnt - vr0, 0);
        exp_q.push_back(8'h74);
        send_frame(8'h74, 1'b0, 1'b1, 6);
        chk("par_good_left", exp_q.size(), 0);
        auto_ack = 1'b0;
`endif

        // Randomized frames against the queue model
        auto_ack = 1'b1;
        fe0 = fe_cnt; ov0 = ov_cnt; pe0 = pe_cnt;
        nbad = 0; npbad = 0;
        for (int n = 0; n < 24; n++) begin
            logic [7:0] b;
            logic       bad_stop, bad_par;
            int         idle;
            b        = 8'($urandom);
            bad_stop = ($urandom_range(0, 4) == 0);
`ifdef UART_RX_PARITY_EN
            bad_par  = ($urandom_range(0, 4) == 0);
`else
            bad_par  = 1'b0;
`endif
            idle = $urandom_range(0, 12);
            if (bad_stop && idle < 2) idle = 2;
            if (!bad_stop && !bad_par) exp_q.push_back(b);
            if (bad_stop) nbad++;
            if (bad_par) npbad++;
            send_frame(b, bad_par, ~bad_stop, idle);
        end
        repeat (8) @(negedge clk);
        chk("rand_left", exp_q.size(), 0);
        chk("rand_ferr", fe_cnt - fe0, nbad);
        chk("rand_perr", pe_cnt - pe0, npbad);
        chk("rand_overrun", ov_cnt - ov0, 0);
        chk("extra_bytes", extra_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver; the receive-side counterpart of the TX path in the same chip design, clocked at 10 MHz.
- Takes the asynchronous serial line and delivers bytes to the message FSM layer through a valid/ack holding register.
- Flags framing errors and overruns.
- Intended bring-up: loop uo_out[0] (TX) back to a ui_in pin to check sent messages.

Parameters:
- CLKS_PER_BIT, 87, clk cycles per bit (10 MHz / 115200, rounded); must equal the TX divisor; min 4.
- PARITY_ODD, 0, parity sense when UART_RX_PARITY_EN is defined (0 = even, 1 = odd); ignored otherwise.

Ports:
- clk  in  1  system clock
- rst_n_clk  in  1  asynchronous, active-low reset
- uart_rxd  in  1  serial line, idle high, asynchronous to clk
- uart_rx_ack  in  1  consumer has taken uart_rx_data
- uart_rx_data  out  8  received byte, LSB first on the wire
- uart_rx_valid  out  1  uart_rx_data holds an unread byte
- uart_rx_busy  out  1  frame reception in progress (state != IDLE)
- uart_rx_frame_err  out  1  one-cycle pulse: stop bit sampled 0
- uart_rx_overrun  out  1  one-cycle pulse: unread byte overwritten
- uart_rx_parity_err  out  1  one-cycle pulse: parity mismatch; tied 0 without the macro

Behaviour:
- Reset: the clock is clk; the reset is rst_n_clk, asynchronous, active-low.
  - Outputs: data=0x00, valid=0, busy=0, all error pulses 0.
  - Synchronizer flops and the edge-detect register reset to 1. State = IDLE.
- Input path:
  - 2-flop synchronizer on uart_rxd, then 1 register for edge detect.
  - A start is a falling edge of the synchronized line.
- Bit timing:
  - Counter width $clog2(CLKS_PER_BIT).
  - HALF = CLKS_PER_BIT/2, truncated.
  - Every sample is taken mid-bit.
- States:
  - IDLE:
    - On a falling edge: clear the counter, go to START.
  - START:
    - After HALF cycles, sample the line.
    - Sample 0: clear the counter, clear bit_idx, go to DATA.
    - Sample 1: treat as a glitch; go to IDLE with no flags.
  - DATA:
    - Every CLKS_PER_BIT cycles, shift the sample into the MSB of the shift register (LSB first).
    - After bit_idx 7 is taken, go to STOP (or PARITY when the macro is on).
  - STOP:
    - After CLKS_PER_BIT cycles, sample the line.
    - Sample 1: deliver the byte.
    - Sample 0: pulse frame_err and discard the byte.
    - Either way, return to IDLE on that cycle (half a bit early) so back-to-back frames are caught.
- Delivery:
  - uart_rx_data and uart_rx_valid update on the cycle after the stop sample.
  - Latency from the first clk edge sampling uart_rxd low to valid=1 is 3 + HALF + 9*CLKS_PER_BIT cycles, ±1.
- Handshake:
  - valid stays high until ack is sampled high; it clears on the next cycle.
  - ack while valid=0 is ignored.
- Simultaneous ack and delivery: the new byte is loaded, valid stays 1, no overrun.
- Delivery while valid=1 and no ack: data is overwritten with the new byte, valid stays 1, overrun pulses for 1 cycle.
- Line held low (break): one frame completes with frame_err. No further start until the line has returned high and fallen again.
- Reset mid-frame: everything returns to reset values at once, and the partial byte is lost. If the line is low at release, at most one spurious frame occurs, ending in frame_err or a glitch reject.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state sits between DATA and STOP and samples one extra bit after CLKS_PER_BIT cycles.
  - Expected bit = ^data XOR PARITY_ODD.
  - On mismatch: parity_err pulses when the STOP sample is taken, and the byte is discarded.
  - If both errors occur, both pulses fire on the same cycle.
- Undefined: no PARITY state, 8N1 only, uart_rx_parity_err constant 0.

Decomposition:
- Package uart_pkg:
  - state encoding localparams (IDLE, START, DATA, PARITY, STOP);
  - default CLKS_PER_BIT;
  - data width 8.
  - Shared with the TX side.
- Sub-module uart_rx_sync: parameterisable 2-flop synchronizer, reset value 1. It is reusable for other ui_in inputs.

Test Plan (bench uses CLKS_PER_BIT=16):
- Single frame 0x42, ack 2 cycles after valid -> valid=1 with data=0x42 about 155 cycles after the start edge; valid=0 after the ack; no error pulses.
- The 11 bytes 0x42 0x61 0x70 0x74 0x69 0x73 0x74 0x65 0x20 0x21 0x0A sent back-to-back, each acked on the cycle valid rises -> all 11 received in order, overrun never pulses.
- 0xA5 with stop bit forced 0, then 0x21 -> one frame_err pulse, valid stays 0; then 0x21 is delivered correctly.
- 3-cycle low glitch, then rst_n_clk asserted mid-frame on 0x74 -> glitch: busy drops by about 11 cycles with no valid; reset: busy=0 and valid=0 immediately; the next 0x61 is received correctly.
- 0x61 then 0x70 with no ack -> overrun pulses once at the second delivery; data=0x70, valid=1.
- With UART_RX_PARITY_EN and PARITY_ODD=0, 0x74 (four 1s) sent with parity bit 1 -> parity_err pulse, no valid; resend with parity bit 0 -> data=0x74.
